// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer driving reg_file/alu via the doALU/ready handshake.
// Optional macro DIV_ZERO_CHECK_EN: resolve DIV/REM by zero locally without issuing to the ALU.
module alu_issue_ctrl #(
  parameter int unsigned TIMEOUT = 4,
  parameter int unsigned MAX_OP  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opcode,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic [63:0] rf_rs1_val,
  input  logic [63:0] rf_rs2_val,
  output logic        rf_write_sig,
  output logic [63:0] rf_write_val,
  output logic [4:0]  rf_write_reg,
  output logic [7:0]  alu_opcode,
  output logic [63:0] alu_value1,
  output logic [63:0] alu_value2,
  output logic [1:0]  alu_doALU,
  input  logic [63:0] alu_result,
  input  logic [1:0]  alu_ready,
  output logic        done,
  output logic        illegal,
  output logic        timeout
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned OPC_W  = 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_OP   = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

`ifdef DIV_ZERO_CHECK_EN
  localparam logic [OPC_W-1:0] OPC_DIV = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_REM = OPC_W'(7);
`endif

  logic [2:0]        state_q, state_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [REG_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic [REG_W-1:0]  rf_rs1_q, rf_rs1_d, rf_rs2_q, rf_rs2_d;
  logic              wr_sig_q, wr_sig_d;
  logic [DATA_W-1:0] wr_val_q, wr_val_d;
  logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic              accept;
  logic              hold_rf;

  // in_ready is also masked by reset so nothing is accepted in a reset cycle
  assign in_ready = in_ready_q & ~reset;
  assign accept   = in_valid & in_ready;

  // Next-state, datapath capture and the in-state ALU drive
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wr_val_d   = '0;
    illegal_d  = 1'b0;
    timeout_d  = 1'b0;
    alu_doALU  = 2'h0;
    alu_opcode = '0;
    alu_value1 = '0;
    alu_value2 = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          opcode_d = in_opcode;
          rs1_d    = in_rs1;
          rs2_d    = in_rs2;
          rd_d     = in_rd;
          if (in_opcode > OPC_W'(MAX_OP)) begin
            state_d   = ST_ERR;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: state_d = ST_OP;
      ST_OP: begin
        cnt_d      = '0;
        alu_opcode = opcode_q;
        alu_value1 = rf_rs1_val;
        alu_value2 = rf_rs2_val;
`ifdef DIV_ZERO_CHECK_EN
        if ((opcode_q == OPC_DIV || opcode_q == OPC_REM) && rf_rs2_val == '0) begin
          wr_val_d = (opcode_q == OPC_DIV) ? '1 : rf_rs1_val;
          state_d  = ST_WB;
        end else begin
          alu_doALU = 2'h1;
          state_d   = ST_WAIT;
        end
`else
        alu_doALU = 2'h1;
        state_d   = ST_WAIT;
`endif
      end
      ST_WAIT: begin
        if (alu_ready == 2'h1) begin
          wr_val_d = alu_result;
          state_d  = ST_WB;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are computed from the upcoming state
    hold_rf    = (state_d == ST_RD) || (state_d == ST_OP) ||
                 (state_d == ST_WAIT) || (state_d == ST_WB);
    in_ready_d = (state_d == ST_IDLE);
    rf_rs1_d   = hold_rf ? rs1_d : '0;
    rf_rs2_d   = hold_rf ? rs2_d : '0;
    wr_sig_d   = (state_d == ST_WB);
    wr_reg_d   = wr_sig_d ? rd_d : '0;
    done_d     = wr_sig_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      opcode_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      rf_rs1_q   <= '0;
      rf_rs2_q   <= '0;
      wr_sig_q   <= 1'b0;
      wr_val_q   <= '0;
      wr_reg_q   <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      rf_rs1_q   <= rf_rs1_d;
      rf_rs2_q   <= rf_rs2_d;
      wr_sig_q   <= wr_sig_d;
      wr_val_q   <= wr_val_d;
      wr_reg_q   <= wr_reg_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  assign rf_rs1       = rf_rs1_q;
  assign rf_rs2       = rf_rs2_q;
  assign rf_write_sig = wr_sig_q;
  assign rf_write_val = wr_val_q;
  assign rf_write_reg = wr_reg_q;
  assign done         = done_q;
  assign illegal      = illegal_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: register-file and ALU models, directed
// vector table, randomized instructions against a timeline model, and reset corner cases.
module tb_alu_issue_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [63:0] rf_rs1_val = 64'd0;
  logic [63:0] rf_rs2_val = 64'd0;
  logic        rf_write_sig;
  logic [63:0] rf_write_val;
  logic [4:0]  rf_write_reg;
  logic [7:0]  alu_opcode;
  logic [63:0] alu_value1, alu_value2;
  logic [1:0]  alu_doALU;
  logic [63:0] alu_result = 64'd0;
  logic [1:0]  alu_ready  = 2'h0;
  logic        done, illegal, timeout;

  alu_issue_ctrl #(.TIMEOUT(TO), .MAX_OP(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .rf_write_sig(rf_write_sig), .rf_write_val(rf_write_val), .rf_write_reg(rf_write_reg),
    .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_doALU(alu_doALU), .alu_result(alu_result), .alu_ready(alu_ready),
    .done(done), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ALU behaviour (unsigned; x/0 = all ones, x%0 = x)
  function automatic logic [63:0] alu_fn(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      8'd0: return a + b;
      8'd1: return a - b;
      8'd2: return a * b;
      8'd3: return (b == 64'd0) ? {64{1'b1}} : a / b;
      8'd4: return a ^ b;
      8'd5: return a & b;
      8'd6: return a | b;
      8'd7: return (b == 64'd0) ? a : a % b;
      8'd8: return ~a;
      default: return 64'd0;
    endcase
  endfunction

  // Register file model: registered read, preload port for the bench, x0 discards writes
  logic [63:0] rf [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [63:0] pl_val = 64'd0;
  always @(posedge clk) begin
    rf_rs1_val <= rf[rf_rs1];
    rf_rs2_val <= rf[rf_rs2];
    if (pl_en) rf[pl_idx] <= pl_val;
    else if (rf_write_sig && rf_write_reg != 5'd0) rf[rf_write_reg] <= rf_write_val;
  end

  // ALU model: answers alu_delay cycles after the earliest slot; noise values 2/3 otherwise
  int alu_delay = 0;
  bit noise_en  = 1'b0;
  int a_cnt     = 0;
  bit a_pend    = 1'b0;
  always @(posedge clk) begin
    alu_ready <= noise_en ? 2'($urandom_range(2, 3)) : 2'h0;
    if (reset) begin
      a_pend <= 1'b0;
    end else if (alu_doALU == 2'h1) begin
      alu_result <= alu_fn(alu_opcode, alu_value1, alu_value2);
      if (alu_delay == 0) alu_ready <= 2'h1;
      else begin
        a_pend <= 1'b1;
        a_cnt  <= alu_delay;
      end
    end else if (a_pend) begin
      if (a_cnt == 1) begin
        alu_ready <= 2'h1;
        a_pend    <= 1'b0;
      end else begin
        a_cnt <= a_cnt - 1;
      end
    end
  end

  function automatic logic outs_nonzero();
    return |{in_ready, rf_rs1, rf_rs2, rf_write_sig, rf_write_val, rf_write_reg,
             alu_opcode, alu_value1, alu_value2, alu_doALU, done, illegal, timeout};
  endfunction

  task automatic set_reg(input logic [4:0] idx, input logic [63:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept_wait"}, 64'(in_ready), 64'd1);
  endtask

  // Issue one instruction and check the whole timeline against the protocol rules
  task automatic run(input logic [7:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input int delay, input bit use_exp,
                     input logic [63:0] exp_tab, input string tag);
    logic [63:0] a, b, exp, wval, g_v1, g_v2;
    logic [7:0]  g_op;
    logic [4:0]  wreg;
    bit          divz;
    int alu_c, wr_c, ill_c, to_c, rdy_c;
    int f_alu, f_wr, f_ill, f_to, f_rdy, n_alu, n_wr, n_ill, n_to, n_done_bad;
    a   = rf[rs1];
    b   = rf[rs2];
    exp = use_exp ? exp_tab : alu_fn(op, a, b);
`ifdef DIV_ZERO_CHECK_EN
    divz = (op == 8'd3 || op == 8'd7) && b == 64'd0;
`else
    divz = 1'b0;
`endif
    alu_c = -1; wr_c = -1; ill_c = -1; to_c = -1;
    if (op > 8'd8) begin
      ill_c = 1; rdy_c = 2;
    end else if (divz) begin
      wr_c = 3; rdy_c = 4;
    end else if (delay < TO) begin
      alu_c = 2; wr_c = 4 + delay; rdy_c = 5 + delay;
    end else begin
      alu_c = 2; to_c = 3 + TO; rdy_c = 4 + TO;
    end
    alu_delay = delay;
    f_alu = -1; f_wr = -1; f_ill = -1; f_to = -1; f_rdy = -1;
    n_alu = 0; n_wr = 0; n_ill = 0; n_to = 0; n_done_bad = 0;
    wval = 64'd0; wreg = 5'd0; g_v1 = 64'd0; g_v2 = 64'd0; g_op = 8'd0;

    wait_ready(tag);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= rdy_c; k++) begin
      if (k > 1) @(negedge clk);
      if (alu_doALU == 2'h1) begin
        n_alu++;
        if (f_alu < 0) begin
          f_alu = k; g_op = alu_opcode; g_v1 = alu_value1; g_v2 = alu_value2;
        end
      end
      if (rf_write_sig) begin
        n_wr++;
        if (f_wr < 0) begin
          f_wr = k; wval = rf_write_val; wreg = rf_write_reg;
        end
      end
      if (done != rf_write_sig) n_done_bad++;
      if (illegal) begin n_ill++; if (f_ill < 0) f_ill = k; end
      if (timeout) begin n_to++;  if (f_to < 0) f_to = k; end
      if (in_ready && f_rdy < 0) f_rdy = k;
    end

    chk({tag, "_alu_cycle"},   64'(f_alu), 64'(alu_c));
    chk({tag, "_alu_count"},   64'(n_alu), 64'((alu_c > 0) ? 1 : 0));
    chk({tag, "_wr_cycle"},    64'(f_wr),  64'(wr_c));
    chk({tag, "_wr_count"},    64'(n_wr),  64'((wr_c > 0) ? 1 : 0));
    chk({tag, "_illegal"},     64'(f_ill), 64'(ill_c));
    chk({tag, "_timeout"},     64'(f_to),  64'(to_c));
    chk({tag, "_err_pulses"},  64'(n_ill + n_to), 64'((ill_c > 0 || to_c > 0) ? 1 : 0));
    chk({tag, "_done_align"},  64'(n_done_bad), 64'd0);
    chk({tag, "_ready_cycle"}, 64'(f_rdy), 64'(rdy_c));
    if (f_wr > 0) begin
      chk({tag, "_wr_val"}, wval, exp);
      chk({tag, "_wr_reg"}, 64'(wreg), 64'(rd));
    end
    if (f_alu > 0) begin
      chk({tag, "_alu_op"}, 64'(g_op), 64'(op));
      chk({tag, "_alu_v1"}, g_v1, a);
      chk({tag, "_alu_v2"}, g_v2, b);
    end
  endtask

  // Assert reset at cycle T+at_k of an instruction, then verify clean recovery
  task automatic reset_mid(input int at_k, input int delay, input logic exp_strobe, input string tag);
    int n_act;
    alu_delay = delay;
    wait_ready(tag);
    in_valid  = 1'b1;
    in_opcode = 8'd0;
    in_rs1    = 5'd1;
    in_rs2    = 5'd2;
    in_rd     = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 2; k <= at_k; k++) @(negedge clk);
    chk({tag, "_strobe_before"}, 64'(rf_write_sig), 64'(exp_strobe));
    reset = 1'b1;
    @(negedge clk);
    chk({tag, "_outs_zero"}, 64'(outs_nonzero()), 64'd0);
    reset = 1'b0;
    n_act = 0;
    @(negedge clk);
    chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      if (rf_write_sig || done || alu_doALU != 2'h0) n_act++;
      if (k < 5) @(negedge clk);
    end
    chk({tag, "_no_activity"}, 64'(n_act), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] v1, v2;
    int          delay;
    logic [63:0] exp;
  } vec_t;

  vec_t tab [10];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_opcode = 8'd0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;

    tab[0] = '{8'd0,   5'd1,  5'd2,  5'd3,  64'd5,     64'd7,    0,  64'd12};
    tab[1] = '{8'd1,   5'd1,  5'd2,  5'd4,  64'd0,     64'd1,    0,  {64{1'b1}}};
    tab[2] = '{8'd9,   5'd1,  5'd2,  5'd5,  64'd3,     64'd4,    0,  64'd0};
    tab[3] = '{8'd0,   5'd1,  5'd2,  5'd6,  64'd3,     64'd4,    TO, 64'd0};
    tab[4] = '{8'd2,   5'd6,  5'd7,  5'd8,  64'd3,     64'd9,    2,  64'd27};
    tab[5] = '{8'd3,   5'd10, 5'd11, 5'd5,  64'd10,    64'd0,    0,  {64{1'b1}}};
    tab[6] = '{8'd7,   5'd10, 5'd11, 5'd12, 64'd10,    64'd0,    0,  64'd10};
    tab[7] = '{8'd8,   5'd13, 5'd14, 5'd0,  64'd0,     64'd2,    1,  {64{1'b1}}};
    tab[8] = '{8'hFF,  5'd13, 5'd14, 5'd15, 64'd1,     64'd2,    0,  64'd0};
    tab[9] = '{8'd6,   5'd16, 5'd17, 5'd18, 64'hF0,    64'h0F,   TO - 1, 64'hFF};

    repeat (3) @(negedge clk);
    chk("reset_outs_zero", 64'(outs_nonzero()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 32; i++) set_reg(5'(i), 64'd0);

    for (int i = 0; i < 10; i++) begin
      set_reg(tab[i].rs1, tab[i].v1);
      set_reg(tab[i].rs2, tab[i].v2);
      run(tab[i].op, tab[i].rs1, tab[i].rs2, tab[i].rd, tab[i].delay, 1'b1, tab[i].exp,
          $sformatf("vec%0d", i));
    end

    noise_en = 1'b1;
    for (int i = 1; i < 32; i++)
      set_reg(5'(i), ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom(), $urandom()});
    for (int i = 0; i < 40; i++) begin
      run(8'($urandom_range(0, 9)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), int'($urandom_range(0, 5)), 1'b0, 64'd0,
          $sformatf("rnd%0d", i));
    end
    noise_en = 1'b0;

    set_reg(5'd1, 64'd20);
    set_reg(5'd2, 64'd22);
    reset_mid(3, 1000, 1'b0, "rst_wait");
    run(8'd0, 5'd1, 5'd2, 5'd9, 0, 1'b1, 64'd42, "post_rst_wait");
    reset_mid(4, 0, 1'b1, "rst_wb");
    run(8'd1, 5'd2, 5'd1, 5'd10, 1, 1'b1, 64'd2, "post_rst_wb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
